l2_cache_nway: RTL

L2_CACHE_NWAY -- requirements
Module: l2_cache_nway

---
 rtl/l2_cache_nway.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back L2 cache, one word per line, true-LRU ages per set.
// A single outstanding request is walked through lookup, optional eviction, optional fill, and response.
module l2_cache_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 512,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int AGE_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_EVICT  = 3'd2,
        S_FILL   = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    function automatic logic [WAYS*AGE_W-1:0] age_init();
        logic [WAYS*AGE_W-1:0] v;
        v = '0;
        for (int i = 0; i < WAYS; i++) begin
            v[i*AGE_W +: AGE_W] = AGE_W'(i);
        end
        return v;
    endfunction

    localparam logic [WAYS-1:0][AGE_W-1:0] AGE_INIT = age_init();

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_req_ready;
    logic                          r_resp_valid;
    logic [DATA_W-1:0]             r_resp_rdata;
    logic                          r_resp_hit;
    logic                          r_mem_req_valid;
    logic                          r_mem_we;
    logic [31:0]                   r_mem_addr;
    logic [DATA_W-1:0]             r_mem_wdata;
    logic [31:0]                   r_hit_cnt;
    logic [31:0]                   r_miss_cnt;
    logic                          r_we;
    logic [IDX_W-1:0]              r_idx;
    logic [TAG_W-1:0]              r_tag;
    logic [DATA_W-1:0]             r_wdata;
    logic [AGE_W-1:0]              r_way;

    logic [SETS-1:0][WAYS-1:0]             r_valid;
    logic [SETS-1:0][WAYS-1:0]             r_dirty;
    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]  r_age;
    logic [TAG_W-1:0]                      r_tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0]                     r_data_mem [SETS][WAYS];

    logic                          w_hit;
    logic [AGE_W-1:0]              w_hit_way;
    logic                          w_inv_found;
    logic [AGE_W-1:0]              w_inv_way;
    logic [AGE_W-1:0]              w_old_way;
    logic [AGE_W-1:0]              w_vic_way;
    logic                          w_vic_dirty;
    logic [AGE_W-1:0]              w_acc_way;
    logic                          w_inst;
    logic                          w_inst_dirty;
    logic                          w_touch;
    logic [DATA_W-1:0]             w_wr_data;
    logic [DATA_W-1:0]             w_resp_data;
    logic                          w_resp_hit;
    logic                          w_hit_inc;
    logic                          w_miss_inc;
    logic [AGE_W-1:0]              w_old_age;
    logic [WAYS-1:0][AGE_W-1:0]    w_new_ages;
    logic                          w_mreq_valid_nxt;
    logic                          w_mwe_nxt;
    logic [31:0]                   w_maddr_nxt;
    logic [DATA_W-1:0]             w_mwdata_nxt;
    logic                          w_unused_addr;

    assign w_unused_addr = ^req_addr[1:0];

    // Tag match and victim selection for the latched set.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_old_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_way   = (r_valid[r_idx][w] && (r_tag_mem[r_idx][w] == r_tag) && !w_hit) ? AGE_W'(w) : w_hit_way;
            w_hit       = w_hit | (r_valid[r_idx][w] && (r_tag_mem[r_idx][w] == r_tag));
            w_inv_way   = (!r_valid[r_idx][w] && !w_inv_found) ? AGE_W'(w) : w_inv_way;
            w_inv_found = w_inv_found | !r_valid[r_idx][w];
            w_old_way   = (r_age[r_idx][w] == AGE_W'(WAYS - 1)) ? AGE_W'(w) : w_old_way;
        end
        w_vic_way   = w_inv_found ? w_inv_way : w_old_way;
        w_vic_dirty = r_valid[r_idx][w_vic_way] && r_dirty[r_idx][w_vic_way];
    end

    // Next state and the per-transition array/response actions.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_way    = r_way;
        w_inst       = 1'b0;
        w_inst_dirty = 1'b0;
        w_touch      = 1'b0;
        w_wr_data    = r_wdata;
        w_resp_data  = '0;
        w_resp_hit   = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_LOOKUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_state_nxt = S_RESP;
                    w_acc_way   = w_hit_way;
                    w_touch     = 1'b1;
                    w_hit_inc   = 1'b1;
                    w_resp_hit  = 1'b1;
                    if (r_we) begin
                        w_inst       = 1'b1;
                        w_inst_dirty = 1'b1;
                        w_resp_data  = r_wdata;
                    end else begin
                        w_resp_data = r_data_mem[r_idx][w_hit_way];
                    end
                end else begin
                    w_acc_way  = w_vic_way;
                    w_miss_inc = 1'b1;
                    if (w_vic_dirty) begin
                        w_state_nxt = S_EVICT;
                    end else if (r_we) begin
                        // Write miss into a clean or empty way: allocate directly.
                        w_state_nxt  = S_RESP;
                        w_inst       = 1'b1;
                        w_inst_dirty = 1'b1;
                        w_touch      = 1'b1;
                        w_resp_data  = r_wdata;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_EVICT: begin
                if (mem_req_ready && r_we) begin
                    w_state_nxt  = S_RESP;
                    w_inst       = 1'b1;
                    w_inst_dirty = 1'b1;
                    w_touch      = 1'b1;
                    w_resp_data  = r_wdata;
                end else if (mem_req_ready) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_EVICT;
                end
            end
            S_FILL: begin
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_RESP;
                    w_inst      = 1'b1;
                    w_touch     = 1'b1;
                    w_wr_data   = mem_rdata;
                    w_resp_data = mem_rdata;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // LRU ages for the accessed set after touching w_acc_way.
    always_comb begin
        w_old_age  = r_age[r_idx][w_acc_way];
        w_new_ages = r_age[r_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == w_acc_way) begin
                w_new_ages[w] = '0;
            end else if (r_age[r_idx][w] < w_old_age) begin
                w_new_ages[w] = r_age[r_idx][w] + AGE_W'(1);
            end else begin
                w_new_ages[w] = r_age[r_idx][w];
            end
        end
    end

    // Memory request fields for the next cycle; the eviction snapshot is taken when leaving lookup.
    always_comb begin
        w_mreq_valid_nxt = 1'b0;
        w_mwe_nxt        = 1'b0;
        w_maddr_nxt      = 32'd0;
        w_mwdata_nxt     = '0;
        case (w_state_nxt)
            S_EVICT: begin
                w_mreq_valid_nxt = 1'b1;
                w_mwe_nxt        = 1'b1;
                if (r_state == S_LOOKUP) begin
                    w_maddr_nxt  = {r_tag_mem[r_idx][w_vic_way], r_idx, 2'b00};
                    w_mwdata_nxt = r_data_mem[r_idx][w_vic_way];
                end else begin
                    w_maddr_nxt  = r_mem_addr;
                    w_mwdata_nxt = r_mem_wdata;
                end
            end
            S_FILL: begin
                w_mreq_valid_nxt = 1'b1;
                w_maddr_nxt      = {r_tag, r_idx, 2'b00};
            end
            default: begin
                w_mreq_valid_nxt = 1'b0;
            end
        endcase
    end

    // Control state, registered outputs, latched request and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_hit      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= 32'd0;
            r_mem_wdata     <= '0;
            r_hit_cnt       <= 32'd0;
            r_miss_cnt      <= 32'd0;
            r_we            <= 1'b0;
            r_idx           <= '0;
            r_tag           <= '0;
            r_wdata         <= '0;
            r_way           <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_req_ready     <= (w_state_nxt == S_IDLE);
            r_resp_valid    <= (w_state_nxt == S_RESP);
            r_resp_rdata    <= (w_state_nxt == S_RESP) ? w_resp_data : '0;
            r_resp_hit      <= w_resp_hit;
            r_mem_req_valid <= w_mreq_valid_nxt;
            r_mem_we        <= w_mwe_nxt;
            r_mem_addr      <= w_maddr_nxt;
            r_mem_wdata     <= w_mwdata_nxt;
            if (w_hit_inc && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss_inc && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if ((r_state == S_IDLE) && req_valid) begin
                r_we    <= req_we;
                r_idx   <= req_addr[IDX_W+1:2];
                r_tag   <= req_addr[31:IDX_W+2];
                r_wdata <= req_wdata;
            end
            if (r_state == S_LOOKUP) begin
                r_way <= w_acc_way;
            end
        end
    end

    // Per-line valid/dirty/age state, cleared on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_age   <= {SETS{AGE_INIT}};
        end else begin
            if (w_inst) begin
                r_valid[r_idx][w_acc_way] <= 1'b1;
                r_dirty[r_idx][w_acc_way] <= w_inst_dirty;
            end
            if (w_touch) begin
                r_age[r_idx] <= w_new_ages;
            end
        end
    end

    // Tag and data storage; contents are qualified by valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_inst) begin
            r_tag_mem[r_idx][w_acc_way]  <= r_tag;
            r_data_mem[r_idx][w_acc_way] <= w_wr_data;
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_hit      = r_resp_hit;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule
